load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit bridging the execute stage to a word-wide data-memory bus
// Optional build macro: LSU_MISALIGN_CHECK_EN rejects misaligned half/word accesses without a bus cycle.
module load_store_unit #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_store,
    input  logic [2:0]           funct3,
    input  logic [WORD_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] store_data,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] load_data,
    output logic                 misaligned,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic [3:0]           mem_be,
    input  logic                 mem_ack,
    input  logic [WORD_SIZE-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    state_t state, state_next;
    size_t  req_size;

    logic [1:0]           req_off;
    logic                 req_mis;
    logic [3:0]           req_be;
    logic [WORD_SIZE-1:0] req_wdata;

    logic [2:0]           funct3_q;
    logic [1:0]           off_q;
    logic                 is_store_q;
    logic [WORD_SIZE-1:0] rshift;
    logic [WORD_SIZE-1:0] ld_ext;

    // funct3 3, 6 and 7 are not RV32I load widths; they fall through to word.
    always_comb begin
        req_size = SZ_WORD;
        case (funct3)
            3'd0, 3'd4: req_size = SZ_BYTE;
            3'd1, 3'd5: req_size = SZ_HALF;
            default:    req_size = SZ_WORD;
        endcase
    end

    always_comb begin
        req_mis   = 1'b0;
        req_off   = addr[1:0];
        req_be    = 4'b1111;
        req_wdata = store_data;
        case (req_size)
            SZ_BYTE: begin
                req_off   = addr[1:0];
                req_be    = 4'b0001 << req_off;
                req_wdata = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
`ifdef LSU_MISALIGN_CHECK_EN
                req_off = addr[1:0];
                req_mis = addr[0];
`else
                req_off = {addr[1], 1'b0};
`endif
                req_be    = 4'b0011 << req_off;
                req_wdata = {2{store_data[15:0]}};
            end
            default: begin
`ifdef LSU_MISALIGN_CHECK_EN
                req_mis = |addr[1:0];
`endif
                req_off   = 2'b00;
                req_be    = 4'b1111;
                req_wdata = store_data;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = req_mis ? DONE : ACCESS;
            ACCESS:  if (mem_ack) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        mem_req = (state == ACCESS);
        done    = (state == DONE);
    end

    assign rshift = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        ld_ext = rshift;
        case (funct3_q)
            3'd0:    ld_ext = {{(WORD_SIZE-8){rshift[7]}}, rshift[7:0]};
            3'd1:    ld_ext = {{(WORD_SIZE-16){rshift[15]}}, rshift[15:0]};
            3'd4:    ld_ext = {{(WORD_SIZE-8){1'b0}}, rshift[7:0]};
            3'd5:    ld_ext = {{(WORD_SIZE-16){1'b0}}, rshift[15:0]};
            default: ld_ext = rshift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_q   <= 3'd0;
            off_q      <= 2'd0;
            is_store_q <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= 4'b0000;
            load_data  <= '0;
        end else begin
            if (state == IDLE && start) begin
                funct3_q   <= funct3;
                off_q      <= req_off;
                is_store_q <= is_store;
                mem_we     <= is_store;
                mem_addr   <= {addr[WORD_SIZE-1:2], 2'b00};
                mem_wdata  <= req_wdata;
                mem_be     <= req_be;
            end
            if (state == ACCESS && mem_ack && !is_store_q)
                load_data <= ld_ext;
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    logic mis_q;

    // Bus-completed requests always capture req_mis = 0, so the flag only survives a rejected access.
    always_ff @(posedge clk) begin
        if (rst)                        mis_q <= 1'b0;
        else if (state == IDLE && start) mis_q <= req_mis;
    end

    assign misaligned = mis_q & (state == DONE);
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit against a behavioural model
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst, start, is_store, mem_ack;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data, mem_rdata;
    logic        busy, done, misaligned, mem_req, mem_we;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_ld  = 32'h0;

    load_store_unit #(.WORD_SIZE(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
        .addr(addr), .store_data(store_data), .busy(busy), .done(done),
        .load_data(load_data), .misaligned(misaligned), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input bit [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic int off_of(input bit [2:0] f3, input logic [31:0] a);
        int sz = size_of(f3);
`ifdef LSU_MISALIGN_CHECK_EN
        return (sz == 4) ? 0 : int'(a % 4);
`else
        if (sz == 1) return int'(a % 4);
        if (sz == 2) return int'(a % 4) & 2;
        return 0;
`endif
    endfunction

    function automatic bit mis_of(input bit [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
        int sz = size_of(f3);
        return (sz == 2 && (a % 2) != 0) || (sz == 4 && (a % 4) != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] load_of(input bit [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int          sz   = size_of(f3);
        longint      mask = (longint'(1) << (8 * sz)) - 1;
        longint      v    = (longint'(rd) >> (8 * off_of(f3, a))) & mask;
        if ((f3 == 3'd0 || f3 == 3'd1) && ((v >> (8 * sz - 1)) & 1) == 1)
            v = v | (~mask);
        return v[31:0];
    endfunction

    // Entered and left at a negedge; start is issued for the following rising edge.
    task automatic run_txn(input bit st, input bit [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input int d, input logic [31:0] rd);
        int          sz  = size_of(f3);
        int          off = off_of(f3, a);
        logic [31:0] be_e, wd_e;
        be_e = ((32'd1 << sz) - 1) << off;
        wd_e = (sz == 1) ? (sd & 32'hFF) * 32'h01010101 :
               (sz == 2) ? (sd & 32'hFFFF) * 32'h00010001 : sd;
        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
        mem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (mis_of(f3, a)) begin
            check("mis_done", done, 1);
            check("mis_flag", misaligned, 1);
            check("mis_req", mem_req, 0);
            check("mis_ld", load_data, exp_ld);
            start = 1'b0; mem_ack = 1'b0;
            @(negedge clk);
            check("mis_idle", busy, 0);
            return;
        end
        check("req", mem_req, 1);
        check("busy", busy, 1);
        check("addr", mem_addr, a & 32'hFFFF_FFFC);
        check("be", mem_be, be_e);
        check("wdata", mem_wdata, wd_e);
        check("we", mem_we, st);
        for (int i = 0; i < d; i++) begin
            mem_ack = 1'b0; mem_rdata = $urandom;
            start = 1'($urandom_range(0, 1)); is_store = 1'($urandom_range(0, 1));
            funct3 = 3'($urandom_range(0, 7)); addr = $urandom; store_data = $urandom;
            @(negedge clk);
            check("req_hold", mem_req, 1);
            check("no_done", done, 0);
            check("be_hold", mem_be, be_e);
        end
        mem_ack = 1'b1; mem_rdata = rd;
        @(negedge clk);
        if (!st) exp_ld = load_of(f3, a, rd);
        check("done", done, 1);
        check("mis_zero", misaligned, 0);
        check("req_drop", mem_req, 0);
        check("ld", load_data, exp_ld);
        mem_ack = 1'b0; start = 1'b0; mem_rdata = $urandom;
        @(negedge clk);
        check("done_pulse", done, 0);
        check("idle", busy, 0);
        check("ld_hold", load_data, exp_ld);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'h0;
        store_data = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_req", mem_req, 0);
        check("rst_done", done, 0);
        check("rst_be", mem_be, 0);
        check("rst_ld", load_data, 0);
        check("rst_addr", mem_addr, 0);
        rst = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        check("stray_ack", busy, 0);
        mem_ack = 1'b0;

        run_txn(0, 3'd2, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        run_txn(0, 3'd0, 32'h103, 32'h0, 1, 32'h80FFFFFF);
        run_txn(0, 3'd4, 32'h103, 32'h0, 0, 32'h80FFFFFF);
        run_txn(1, 3'd1, 32'h202, 32'h1234ABCD, 3, 32'h0);
        run_txn(0, 3'd2, 32'h101, 32'h0, 0, 32'hCAFEF00D);

        start = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h300;
        @(negedge clk);
        check("pre_rst_req", mem_req, 1);
        rst = 1'b1; mem_ack = 1'b1;
        @(negedge clk);
        check("rst_acc_req", mem_req, 0);
        check("rst_acc_done", done, 0);
        check("rst_acc_busy", busy, 0);
        check("rst_acc_ld", load_data, 0);
        check("rst_acc_we", mem_we, 0);
        rst = 1'b0; mem_ack = 1'b0; start = 1'b0; exp_ld = 32'h0;
        @(negedge clk);
        check("post_rst_done", done, 0);
        run_txn(0, 3'd5, 32'h402, 32'h0, 2, 32'h8001_7FFF);

        for (int n = 0; n < 200; n++)
            run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                    $urandom, $urandom_range(0, 3), $urandom);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
